m_unit_seq: RTL and testbench

Multi-cycle sequencer for the RV32M unit in the execute stage. It accepts one M-extension operation at a time and runs it to completion. Multiplies use a registered two-cycle product path. Divides and remainders use a 32-step iterative restoring divider on operand magnitudes, followed by sign correction. While an operation is in flight, the block holds the pipeline through `stall_o` and reports the result with a one-cycle `valid_o` pulse.

---
 rtl/m_unit_seq_pkg.sv | 44 ++++
 rtl/m_unit_seq_div_step.sv | 28 ++
 rtl/m_unit_seq.sv | 154 +++++++++++++++
 tb/tb_m_unit_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/m_unit_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle sequencer: funct3 codes, FSM states, operand helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package m_unit_seq_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] M_OP_MUL    = 3'b000;
    localparam logic [2:0] M_OP_MULH   = 3'b001;
    localparam logic [2:0] M_OP_MULHSU = 3'b010;
    localparam logic [2:0] M_OP_MULHU  = 3'b011;
    localparam logic [2:0] M_OP_DIV    = 3'b100;
    localparam logic [2:0] M_OP_DIVU   = 3'b101;
    localparam logic [2:0] M_OP_REM    = 3'b110;
    localparam logic [2:0] M_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MSEQ_IDLE = 2'd0,
        MSEQ_MUL  = 2'd1,
        MSEQ_DIV  = 2'd2,
        MSEQ_DONE = 2'd3
    } mseq_state_e;

    // rs1 is treated as signed by every signed multiply/divide variant
    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == M_OP_MUL) || (op == M_OP_MULH) || (op == M_OP_MULHSU) ||
               (op == M_OP_DIV) || (op == M_OP_REM);
    endfunction

    // rs2 is unsigned for MULHSU in addition to the purely unsigned ops
    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == M_OP_MUL) || (op == M_OP_MULH) ||
               (op == M_OP_DIV) || (op == M_OP_REM);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/m_unit_seq_div_step.sv
// One restoring-division step: shift remainder:quotient left, trial-subtract divisor, keep if no borrow.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the step result is registered.
module m_div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] div_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [33:0] shifted;
    logic [33:0] diff;

    // Extra top bit makes the borrow of the trial subtraction explicit
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted - {2'b00, div_i};
        if (!diff[33]) begin
            rem_o = diff[32:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[32:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/m_unit_seq.sv
// RV32M sequencer: one M op at a time, two-cycle registered multiply, 32-step restoring divide.
// Latency: MUL* valid at cycle 2, regular DIV/REM at cycle 33, div-by-zero/overflow at cycle 1.
// Backpressure: stall_o holds the pipeline while in flight; start_i is ignored unless IDLE.
module m_unit_seq
    import m_unit_seq_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    mseq_state_e state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] mag1_q, mag1_d;
    logic [31:0] mag2_q, mag2_d;
    logic        sign_q, sign_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic        s1, s2;
    logic [63:0] prod, prod_s;
    logic [32:0] step_rem;
    logic [31:0] step_quo;

    m_div_step u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (mag2_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state, operand capture and result selection
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mag1_d   = mag1_q;
        mag2_d   = mag2_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        s1     = rs1_is_signed(op_i) & rs1_i[31];
        s2     = rs2_is_signed(op_i) & rs2_i[31];
        prod   = {32'd0, mag1_q} * {32'd0, mag2_q};
        prod_s = sign_q ? (~prod + 64'd1) : prod;

        case (state_q)
            MSEQ_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d   = op_i;
                    mag1_d = mag32(rs1_i, rs1_is_signed(op_i));
                    mag2_d = mag32(rs2_i, rs2_is_signed(op_i));
                    case (op_i)
                        M_OP_MUL, M_OP_MULH, M_OP_DIV: sign_d = s1 ^ s2;
                        M_OP_MULHSU, M_OP_REM:         sign_d = s1;
                        default:                       sign_d = 1'b0;
                    endcase
                    if (!op_i[2]) begin
                        state_d = MSEQ_MUL;
                    end else if (rs2_i == 32'd0) begin
                        // Divide by zero: quotient all ones, remainder is the raw dividend
                        state_d  = MSEQ_DONE;
                        result_d = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
                    end else if (!op_i[0] && rs1_i == 32'h8000_0000 && rs2_i == 32'hFFFF_FFFF) begin
                        state_d  = MSEQ_DONE;
                        result_d = op_i[1] ? 32'd0 : 32'h8000_0000;
                    end else begin
                        state_d = MSEQ_DIV;
                        cnt_d   = 5'd31;
                        rem_d   = 33'd0;
                        quo_d   = mag32(rs1_i, rs1_is_signed(op_i));
                    end
                end
            end
            MSEQ_MUL: begin
                if (flush_i) begin
                    state_d = MSEQ_IDLE;
                end else begin
                    state_d  = MSEQ_DONE;
                    result_d = (op_q == M_OP_MUL) ? prod_s[31:0] : prod_s[63:32];
                end
            end
            MSEQ_DIV: begin
                if (flush_i) begin
                    state_d = MSEQ_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == 5'd0) begin
                        state_d = MSEQ_DONE;
                        if (op_q[1]) begin
                            result_d = sign_q ? neg32(step_rem[31:0]) : step_rem[31:0];
                        end else begin
                            result_d = sign_q ? neg32(step_quo) : step_quo;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            default: begin
                state_d = MSEQ_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MSEQ_IDLE;
            op_q     <= 3'd0;
            mag1_q   <= 32'd0;
            mag2_q   <= 32'd0;
            sign_q   <= 1'b0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mag1_q   <= mag1_d;
            mag2_q   <= mag2_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Reset wins over a held start, so no stall is requested while rst_i is high
    assign stall_o  = !rst_i && (((state_q == MSEQ_IDLE) && start_i) ||
                                 (state_q == MSEQ_MUL) || (state_q == MSEQ_DIV));
    assign busy_o   = (state_q != MSEQ_IDLE);
    assign valid_o  = (state_q == MSEQ_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_m_unit_seq.sv
module tb_m_unit_seq;
    import m_unit_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o, stall_o, valid_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;

    m_unit_seq dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue at cycle 0, then wait (bounded) for valid_o and check cycle, value and hold
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        int n;
        op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
        #1;
        chk({tag, " stall c0"}, 32'(stall_o), 32'd1);
        step();
        start_i = 1'b0;
        n = 1;
        while (!valid_o && n < 40) begin
            chk({tag, " stall busy"}, 32'(stall_o), 32'd1);
            step();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " result"}, result_o, exp);
        chk({tag, " stall done"}, 32'(stall_o), 32'd0);
        step();
        chk({tag, " busy after"}, 32'(busy_o), 32'd0);
        chk({tag, " valid pulse"}, 32'(valid_o), 32'd0);
        chk({tag, " result hold"}, result_o, exp);
    endtask

    initial begin
        step();
        step();
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst valid", 32'(valid_o), 32'd0);
        chk("rst result", result_o, 32'd0);
        chk("rst stall", 32'(stall_o), 32'd0);
        rst_i = 1'b0;
        step();

        run_op("MUL -3*5", M_OP_MUL, 32'hFFFF_FFFD, 32'd5, 2, 32'hFFFF_FFF1);
        run_op("MULH", M_OP_MULH, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
        run_op("MULHU", M_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        run_op("MULHSU", M_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
        run_op("DIVU 100/7", M_OP_DIVU, 32'd100, 32'd7, 33, 32'd14);
        run_op("REM -7%2", M_OP_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_op("DIV -7/2", M_OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_op("DIV ovf", M_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("REM ovf", M_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        run_op("DIV 5/0", M_OP_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("REMU 5/0", M_OP_REMU, 32'd5, 32'd0, 1, 32'd5);

        // Flush of an in-flight divide at cycle 10
        op_i = M_OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (9) step();
        flush_i = 1'b1;
        #1;
        chk("flush c10 valid", 32'(valid_o), 32'd0);
        step();
        flush_i = 1'b0;
        chk("flush c11 busy", 32'(busy_o), 32'd0);
        chk("flush c11 valid", 32'(valid_o), 32'd0);
        chk("flush result kept", result_o, 32'd5);
        run_op("MUL 2*3 after flush", M_OP_MUL, 32'd2, 32'd3, 2, 32'd6);

        // Flush during DONE does not suppress the pulse
        op_i = M_OP_MUL; rs1_i = 32'd4; rs2_i = 32'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        flush_i = 1'b1;
        #1;
        chk("flush done valid", 32'(valid_o), 32'd1);
        chk("flush done result", result_o, 32'd20);
        step();
        flush_i = 1'b0;
        chk("flush done idle", 32'(busy_o), 32'd0);

        // Flush together with start in IDLE drops the start
        op_i = M_OP_MUL; rs1_i = 32'd7; rs2_i = 32'd7; start_i = 1'b1; flush_i = 1'b1;
        step();
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush+start dropped", 32'(busy_o), 32'd0);

        // Reset at cycle 20 of a divide, start held through reset
        op_i = M_OP_DIV; rs1_i = 32'd1000; rs2_i = 32'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (19) step();
        chk("div c20 busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1; start_i = 1'b1; op_i = M_OP_MUL; rs1_i = 32'd2; rs2_i = 32'd3;
        step();
        chk("rst mid busy", 32'(busy_o), 32'd0);
        chk("rst mid valid", 32'(valid_o), 32'd0);
        chk("rst mid result", result_o, 32'd0);
        chk("rst mid stall", 32'(stall_o), 32'd0);
        step();
        rst_i = 1'b0; start_i = 1'b0;
        step();
        chk("start in rst ignored", 32'(busy_o), 32'd0);
        chk("start in rst no valid", 32'(valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
